// File: rtl/multimode_modem_core.sv
// multimode_modem_core: four-mode modulator (OOK, BFSK, BPSK, QPSK) fed by a
// valid/ready bit FIFO and driving an unsigned DAC bus, plus a coherent
// symbol-window demodulator. Timers, the NCO and demod windows advance only
// on samp_en.
// Optional feature macro: LOOPBACK_EN -- when defined, the demodulator input
// is taken from mod_out instead of rx_sample (self-test path).
module multimode_modem_core #(
    parameter int DAC_W      = 7,
    parameter int PHASE_W    = 8,
    parameter int SPS        = 16,
    parameter int F0_INC     = 16,
    parameter int F1_INC     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ASK_TH     = 16,
    parameter int FSK_TH     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             samp_en,
    input  logic [1:0]       mode,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DAC_W-1:0] mod_out,
    output logic             tx_busy,
    input  logic [DAC_W-1:0] rx_sample,
    output logic [1:0]       demod_bits,
    output logic             demod_valid
);

    typedef enum logic [1:0] {
        MODE_OOK  = 2'b00,
        MODE_BFSK = 2'b01,
        MODE_BPSK = 2'b10,
        MODE_QPSK = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SYM  = 1'b1
    } tx_state_e;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(SPS);
    localparam int ACC_W = $clog2(SPS) + 1;

    localparam logic [DAC_W-1:0]        MID       = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [DAC_W-1:0]        ASK_TH_V  = DAC_W'(ASK_TH);
    localparam logic [PHASE_W-1:0]      INC0      = PHASE_W'(F0_INC);
    localparam logic [PHASE_W-1:0]      INC1      = PHASE_W'(F1_INC);
    localparam logic [PHASE_W-1:0]      QTR       = {2'b01, {(PHASE_W-2){1'b0}}};
    localparam logic [CNT_W-1:0]        LAST_CNT  = CNT_W'(SPS - 1);
    localparam logic [PTR_W:0]          FULL_OCC  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [ACC_W-1:0]        OOK_CNT_TH = ACC_W'(SPS / 4);
    localparam logic [ACC_W-1:0]        FSK_TH_V  = ACC_W'(FSK_TH);
    localparam logic [ACC_W-1:0]        HALF_V    = ACC_W'(SPS / 2);
    localparam logic signed [ACC_W:0]   HALF_S    = (ACC_W+1)'(SPS / 2);

    // Triangle carrier: fold the phase around its MSB, keep the top DAC_W bits.
    function automatic logic [DAC_W-1:0] carrier(input logic [PHASE_W-1:0] ph);
        logic [PHASE_W-2:0] tri_v;
        tri_v = ph[PHASE_W-1] ? ~ph[PHASE_W-2:0] : ph[PHASE_W-2:0];
        return tri_v[PHASE_W-2 -: DAC_W];
    endfunction

    // ---------------- bit FIFO ----------------
    logic [FIFO_DEPTH-1:0] fifo_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [PTR_W:0]        occ_q, need, pop_n;
    logic                  rdy_en_q, push, head0, head1;

    // ---------------- transmitter ----------------
    tx_state_e             state_q;
    mode_e                 mode_q;
    logic [1:0]            sym_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [PHASE_W-1:0]    phase_q, inc;
    logic [DAC_W-1:0]      mod_out_q, samp_d;
    logic                  boundary, start;

    assign in_ready = rdy_en_q && (occ_q != FULL_OCC);
    assign push     = in_valid && in_ready;
    assign rd_nxt   = rd_ptr_q + PTR_W'(1);
    assign head0    = fifo_q[rd_ptr_q];
    assign head1    = fifo_q[rd_nxt];
    assign need     = (mode_e'(mode) == MODE_QPSK) ? (PTR_W+1)'(2) : (PTR_W+1)'(1);
    assign boundary = samp_en && ((state_q == ST_IDLE) || (cnt_q == LAST_CNT));
    assign start    = boundary && (occ_q >= need);
    assign pop_n    = start ? need : '0;
    assign inc      = (mode_q == MODE_BFSK && sym_q[0]) ? INC1 : INC0;
    assign tx_busy  = (state_q == ST_SYM);
    assign mod_out  = mod_out_q;

    // FIFO storage and pointers; occupancy uses pre-pop value for in_ready
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_bit;
        end
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q <= rd_ptr_q + pop_n[PTR_W-1:0];
            occ_q    <= occ_q + {{PTR_W{1'b0}}, push} - pop_n;
        end
    end

    // Symbol FSM: latch mode and pop bits at each boundary, else run timer/NCO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OOK;
            cnt_q   <= '0;
            phase_q <= '0;
        end else if (boundary) begin
            mode_q  <= mode_e'(mode);
            cnt_q   <= '0;
            phase_q <= '0;
            if (start) begin
                state_q <= ST_SYM;
                sym_q   <= (mode_e'(mode) == MODE_QPSK) ? {head0, head1} : {1'b0, head0};
            end else begin
                state_q <= ST_IDLE;
            end
        end else if (samp_en) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            phase_q <= phase_q + inc;
        end
    end

    // Per-mode sample for the current phase
    always_comb begin
        samp_d = MID;
        if (state_q == ST_SYM) begin
            case (mode_q)
                MODE_OOK:  samp_d = sym_q[0] ? carrier(phase_q) : MID;
                MODE_BFSK: samp_d = carrier(phase_q);
                MODE_BPSK: samp_d = carrier(phase_q + {sym_q[0], {(PHASE_W-1){1'b0}}});
                default:   samp_d = carrier(phase_q + {sym_q, {(PHASE_W-2){1'b0}}});
            endcase
        end
    end

    // Output sample register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mod_out_q <= MID;
        end else begin
            mod_out_q <= samp_d;
        end
    end

    // ---------------- demodulator ----------------
    logic [DAC_W-1:0]   rx_v;

`ifdef LOOPBACK_EN
    logic unused_rx;
    assign unused_rx = ^rx_sample;
    assign rx_v      = mod_out_q;
`else
    assign rx_v      = rx_sample;
`endif

    logic               busy_dly_q, prev_sign_q, valid_q;
    logic [CNT_W-1:0]   cnt_dly_q;
    logic [PHASE_W-1:0] phase_dly_q;
    mode_e              mode_dly_q;
    logic [ACC_W-1:0]   amp_q, zc_q, ai_q, aq_q;
    logic [ACC_W-1:0]   amp_n, zc_n, ai_n, aq_n;
    logic [1:0]         bits_q, dec;
    logic               rx_sign, i_sign, q_sign, amp_hit, zc_hit;
    logic signed [ACC_W:0] di, dq;
    logic [ACC_W:0]     adi, adq;

    assign demod_bits  = bits_q;
    assign demod_valid = valid_q;

    // Tx state delayed by one sample strobe to match loopback latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_dly_q  <= 1'b0;
            cnt_dly_q   <= '0;
            phase_dly_q <= '0;
            mode_dly_q  <= MODE_OOK;
        end else if (samp_en) begin
            busy_dly_q  <= tx_busy;
            cnt_dly_q   <= cnt_q;
            phase_dly_q <= phase_q;
            mode_dly_q  <= mode_q;
        end
    end

    // Per-sample statistics folded into the running window and the decision
    always_comb begin
        rx_sign = (rx_v >= MID);
        i_sign  = (carrier(phase_dly_q) >= MID);
        q_sign  = (carrier(phase_dly_q + QTR) >= MID);
        amp_hit = (rx_v >= MID) ? ((rx_v - MID) > ASK_TH_V) : ((MID - rx_v) > ASK_TH_V);
        zc_hit  = (cnt_dly_q != '0) && (rx_sign != prev_sign_q);
        amp_n   = amp_q + {{(ACC_W-1){1'b0}}, amp_hit};
        zc_n    = zc_q  + {{(ACC_W-1){1'b0}}, zc_hit};
        ai_n    = ai_q  + {{(ACC_W-1){1'b0}}, (rx_sign == i_sign)};
        aq_n    = aq_q  + {{(ACC_W-1){1'b0}}, (rx_sign == q_sign)};
        di      = $signed({1'b0, ai_n}) - HALF_S;
        dq      = $signed({1'b0, aq_n}) - HALF_S;
        adi     = (di < 0) ? -di : di;
        adq     = (dq < 0) ? -dq : dq;
        dec     = 2'b00;
        case (mode_dly_q)
            MODE_OOK:  dec = {1'b0, (amp_n > OOK_CNT_TH)};
            MODE_BFSK: dec = {1'b0, (zc_n > FSK_TH_V)};
            MODE_BPSK: dec = {1'b0, (ai_n < HALF_V)};
            default: begin
                if (adi >= adq) begin
                    dec = (di > 0) ? 2'd0 : 2'd2;
                end else begin
                    dec = (dq > 0) ? 2'd1 : 2'd3;
                end
            end
        endcase
    end

    // Window accumulators; decide and clear on the window's last sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            amp_q       <= '0;
            zc_q        <= '0;
            ai_q        <= '0;
            aq_q        <= '0;
            prev_sign_q <= 1'b0;
            valid_q     <= 1'b0;
            bits_q      <= 2'b00;
        end else begin
            valid_q <= 1'b0;
            if (samp_en && busy_dly_q) begin
                prev_sign_q <= rx_sign;
                if (cnt_dly_q == LAST_CNT) begin
                    amp_q   <= '0;
                    zc_q    <= '0;
                    ai_q    <= '0;
                    aq_q    <= '0;
                    valid_q <= 1'b1;
                    bits_q  <= dec;
                end else begin
                    amp_q <= amp_n;
                    zc_q  <= zc_n;
                    ai_q  <= ai_n;
                    aq_q  <= aq_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_multimode_modem_core.sv
// Scoreboard bench for multimode_modem_core: stimulus pushes expected demod
// symbols, a monitor pops and compares on every demod_valid pulse. The rx
// input is wired to mod_out so both builds see the same loopback path.
module tb_multimode_modem_core;
    localparam int DAC_W = 7;
    localparam int MID   = 64;

    logic             clk = 1'b0;
    logic             rst_n, samp_en, in_bit, in_valid;
    logic             in_ready, tx_busy, demod_valid;
    logic [1:0]       mode, demod_bits;
    logic [DAC_W-1:0] mod_out, rx_sample;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    assign rx_sample = mod_out;

    multimode_modem_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .samp_en     (samp_en),
        .mode        (mode),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mod_out     (mod_out),
        .tx_busy     (tx_busy),
        .rx_sample   (rx_sample),
        .demod_bits  (demod_bits),
        .demod_valid (demod_valid)
    );

    // Reference triangle carrier for PHASE_W=8, DAC_W=7
    function automatic int tri_ref(input int p);
        int m;
        m = p % 256;
        return (m < 128) ? m : (255 - m);
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_bit(input logic b);
        check("push_in_ready", int'(in_ready), 1);
        in_bit   = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Monitor: compare each decided symbol against the scoreboard
    always @(negedge clk) begin : monitor
        logic [1:0] e;
        if (rst_n === 1'b1 && demod_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL demod_unexpected: got bits=%0d expected no output", demod_bits);
            end else begin
                e = exp_q.pop_front();
                check("demod_bits", int'(demod_bits), int'(e));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int busy_n;
        int acc;
        logic [4:0] fb;

        // Reset with strobe and valid active
        rst_n    = 1'b0;
        samp_en  = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        mode     = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_mod_out", int'(mod_out), MID);
        check("reset_demod_valid", int'(demod_valid), 0);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_tx_busy", int'(tx_busy), 0);
        check("reset_demod_bits", int'(demod_bits), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_release", int'(in_ready), 1);
        check("idle_tx_busy", int'(tx_busy), 0);
        samp_en = 1'b0;

        // OOK: bits 1,0 -> carrier then MID, then idle MID
        mode = 2'b00;
        push_bit(1'b1);
        push_bit(1'b0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        samp_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            check("ook_mod_out", int'(mod_out), (i < 16) ? tri_ref(16 * i) : MID);
            if (i == 0) check("ook_busy_start", int'(tx_busy), 1);
            if (i == 47) check("ook_busy_end", int'(tx_busy), 0);
        end
        wait_drain("ook");
        samp_en = 1'b0;

        // BFSK: bits 0,1
        mode = 2'b01;
        push_bit(1'b0);
        push_bit(1'b1);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        samp_en = 1'b1;
        wait_drain("bfsk");
        samp_en = 1'b0;

        // BPSK: bits 1,0; first symbol starts inverted at full scale
        mode = 2'b10;
        push_bit(1'b1);
        push_bit(1'b0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        samp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bpsk_first_sample", int'(mod_out), 127);
        wait_drain("bpsk");
        samp_en = 1'b0;

        // QPSK: bits 1,1,0,1 -> dibits 3,1; busy for exactly two symbols
        mode = 2'b11;
        push_bit(1'b1);
        push_bit(1'b1);
        push_bit(1'b0);
        push_bit(1'b1);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        samp_en = 1'b1;
        busy_n  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_busy) busy_n++;
        end
        check("qpsk_busy_samples", busy_n, 32);
        wait_drain("qpsk");
        samp_en = 1'b0;

        // FIFO full / single pop / underrun in BPSK
        mode     = 2'b10;
        fb       = 5'b01101;
        acc      = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_bit = fb[i];
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("fifo_accepted", acc, 4);
        check("fifo_full_in_ready", int'(in_ready), 0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        samp_en = 1'b1;
        @(negedge clk);
        samp_en = 1'b0;
        check("fifo_ready_after_pop", int'(in_ready), 1);
        check("fifo_busy_after_pop", int'(tx_busy), 1);
        @(negedge clk);
        samp_en = 1'b1;
        wait_drain("fifo");
        check("underrun_mod_out", int'(mod_out), MID);
        check("underrun_tx_busy", int'(tx_busy), 0);
        samp_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multimode_modem_core.md
Name: multimode_modem_core

Overview:
- Parametrised successor to the 2-bit-select modem top: a 4-mode modulator (OOK, BFSK, BPSK, QPSK) driving an unsigned DAC sample bus, plus a coherent symbol-window demodulator.
- Input bits arrive through a valid/ready bit FIFO. The symbol timer, NCO and demod windows advance only on a sample strobe.
- Sits directly under the TinyTapeout wrapper: mode from ui_in[1:0], mod_out onto uo_out[6:0], demod bit onto uo_out[7].

Parameters:
- DAC_W, 7, output/rx sample width. Must satisfy DAC_W <= PHASE_W-1.
- PHASE_W, 8, NCO phase accumulator width.
- SPS, 16, samples per symbol (>=4, power of 2).
- F0_INC, 16, phase increment for carrier / FSK bit 0.
- F1_INC, 32, phase increment for FSK bit 1.
- FIFO_DEPTH, 4, bit FIFO depth (power of 2, >=2).
- ASK_TH, 16, OOK amplitude threshold against MID.
- FSK_TH, 3, FSK zero-crossing decision threshold.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- samp_en, in, 1, sample strobe; all timers advance only when high.
- mode, in, 2, 00 OOK, 01 BFSK, 10 BPSK, 11 QPSK.
- in_bit, in, 1, tx data bit.
- in_valid, in, 1, in_bit valid.
- in_ready, out, 1, FIFO not full.
- mod_out, out, DAC_W, modulated sample (registered).
- tx_busy, out, 1, a symbol is being transmitted.
- rx_sample, in, DAC_W, received sample.
- demod_bits, out, 2, decided symbol; bit0 only in 1-bit modes.
- demod_valid, out, 1, one-cycle pulse per decided symbol.

Behaviour:
- MID = 2^(DAC_W-1).
- Reset (rst_n low at a clk edge): mod_out=MID, tx_busy=0, demod_bits=0, demod_valid=0, in_ready=0; FIFO, phase, symbol counter and demod accumulators cleared. in_ready=1 on the first cycle after release. Reset mid-symbol aborts the symbol and discards FIFO contents.
- FIFO: push when in_valid&&in_ready. in_ready = !full, computed from pre-pop occupancy, so simultaneous push+pop when full is not accepted. First bit in is first out.
- Symbol timer: counter 0..SPS-1, increments on samp_en, wraps to 0.
- Boundary: a samp_en cycle with counter==SPS-1, or the idle state. At a boundary:
  - mode is latched.
  - Bits needed: 1 in OOK/BFSK/BPSK; 2 in QPSK (first popped bit = dibit MSB).
  - If occupancy >= needed: pop, tx_busy=1, phase reset to 0, counter=0.
  - Otherwise: tx_busy=0, mod_out=MID, and the core re-checks on every samp_en.
- NCO: on samp_en, phase += inc, modulo 2^PHASE_W.
  - tri = phase[PHASE_W-1] ? ~phase[PHASE_W-2:0] : phase[PHASE_W-2:0].
  - carrier = top DAC_W bits of tri.
- Per-mode output:
  - OOK: bit1 carrier (inc F0); bit0 MID.
  - BFSK: inc F0/F1 by bit.
  - BPSK: carrier of phase + bit*2^(PHASE_W-1).
  - QPSK: carrier of phase + dibit*2^(PHASE_W-2).
  - mod_out registers the sample for the current phase, one cycle after samp_en.
- Demod:
  - Window = SPS accepted rx samples, aligned to the tx symbol counter delayed by one samp_en (loopback latency).
  - Local references: I = carrier(phase), Q = carrier(phase + 2^(PHASE_W-2)). sign(x) = x >= MID.
  - OOK: bit = count(|rx-MID| > ASK_TH) > SPS/4.
  - BFSK: bit = count(sign changes) > FSK_TH.
  - BPSK: bit = aI < SPS/2, where aI = count(sign rx == sign I).
  - QPSK: aQ likewise against Q. dI = aI - SPS/2, dQ = aQ - SPS/2. If |dI| >= |dQ|: dibit = dI>0 ? 0 : 2; else dibit = dQ>0 ? 1 : 3.
  - demod_valid pulses one cycle after the window's last sample; accumulators then clear. Windows run only while the delayed tx_busy is high.
- Mode changes mid-symbol have no effect until the next boundary.

Optional Feature:
- LOOPBACK_EN:
  - Defined: the demod input is internally muxed to mod_out (rx_sample ignored), giving a self-test path.
  - Undefined: rx_sample drives the demod, and the mux and its logic are absent.

Test Plan:
- Reset with samp_en=1 and in_valid=1 -> mod_out=64, demod_valid=0, in_ready=0; in_ready=1 one cycle after rst_n rises.
- LOOPBACK_EN, OOK, bits 1,0, samp_en constant -> mod_out 0,16,32,...,112,127,111,...,15 then 64 for 16 samples; demod_bits 1 then 0.
- BFSK bits 0,1 loopback -> 2 then 4 sign changes per window; demod_bits 0,1.
- BPSK bits 1,0 -> first symbol starts at 127 (inverted); demod_bits 1,0.
- QPSK bits 1,1,0,1 -> dibits 3,1 decided as 3,1; tx_busy drops after 32 samples.
- Hold samp_en=0 while pushing 5 bits -> 4 accepted, in_ready=0. One boundary in BPSK pops 1 -> in_ready=1. Underrun -> mod_out=MID, tx_busy=0.
